// File: rtl/alu_op_issuer_pkg.sv
// Purpose: shared types and sizing helpers for the ALU command issuer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding (2-bit) and command record width CMD_W = 2 + 2*WIDTH.
package alu_issuer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of one buffered command: opcode plus both operands.
  function automatic int cmd_width(input int width);
    return 2 + 2 * width;
  endfunction

  localparam int CMD_W = cmd_width(DEFAULT_WIDTH);

endpackage

// File: rtl/alu_op_issuer_if.sv
// Purpose: bundles the command, ALU-control and response channels of the issuer.
// Latency: n/a (wires only).
// Backpressure: cmd channel via cmd_ready, rsp channel via rsp_ready.
// Modports: master = issuer side (drives cmd_ready, alu_*, rsp_*, busy);
//           slave  = environment side (command source, ALU control, response sink).
interface alu_op_issuer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [1:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_en;
  logic             alu_done;
  logic [WIDTH-1:0] alu_res;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_opcode;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_err;

  logic             busy;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b,
    output cmd_ready,
    output alu_opcode, alu_a, alu_b, alu_en,
    input  alu_done, alu_res,
    output rsp_valid, rsp_opcode, rsp_res, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_opcode, alu_a, alu_b, alu_en,
    output alu_done, alu_res,
    input  rsp_valid, rsp_opcode, rsp_res, rsp_err,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/alu_op_issuer_cmd_fifo.sv
// Purpose: synchronous show-ahead FIFO holding pending ALU commands.
// Latency: a push at edge t is visible on dout/empty in the cycle after edge t.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: clk, rst (sync, active-high), push, pop, din, dout (head entry), full, empty.
module alu_cmd_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Purpose: buffers ALU commands and issues them one at a time (en pulse, wait done, return result).
// Latency: command accepted at edge t -> alu_en in cycle t+2; alu_done in cycle k -> rsp_valid in k+1.
// Backpressure: cmd_ready = FIFO not full; a pending response stalls issue until rsp_ready.
// Ports: clk, rst (sync, active-high), bus (alu_op_issuer_if.master: cmd_*, alu_*, rsp_*, busy).
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  alu_op_issuer_if.master bus
);

  localparam int CW = cmd_width(WIDTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic [1:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t   cmd_in;
  cmd_t   fifo_dout;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_push;
  logic   fifo_pop;

  state_t           state_q,      state_d;
  logic [TW-1:0]    timer_q,      timer_d;
  cmd_t             op_q,         op_d;
  logic             alu_en_q,     alu_en_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [1:0]       rsp_opcode_q, rsp_opcode_d;
  logic [WIDTH-1:0] rsp_res_q,    rsp_res_d;
  logic             rsp_err_q,    rsp_err_d;

  assign cmd_in    = {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
  assign fifo_push = bus.cmd_valid && !fifo_full;
  // Only IDLE consumes the head, so at most one command is ever outstanding.
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    op_d         = op_q;
    alu_en_d     = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_res_d    = rsp_res_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          op_d     = fifo_dout;
          alu_en_d = 1'b1;   // registered, so the pulse lands in the ISSUE cycle
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // done is checked before the timeout so a done on the last cycle still succeeds
        if (bus.alu_done) begin
          rsp_valid_d  = 1'b1;
          rsp_opcode_d = op_q.opcode;
          rsp_res_d    = bus.alu_res;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d  = 1'b1;
          rsp_opcode_d = op_q.opcode;
          rsp_res_d    = '0;
          rsp_err_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      op_q         <= '0;
      alu_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_res_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      op_q         <= op_d;
      alu_en_q     <= alu_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_res_q    <= rsp_res_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.alu_opcode = op_q.opcode;
  assign bus.alu_a      = op_q.a;
  assign bus.alu_b      = op_q.b;
  assign bus.alu_en     = alu_en_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_res    = rsp_res_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Purpose: self-checking bench for alu_op_issuer against a queue-based reference model.
// Latency: n/a.
// Backpressure: bench drives rsp_ready directly or randomly.
module tb_alu_op_issuer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issuer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_issuer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_s;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] res;
    logic             err;
    logic [31:0]      lat;
  } exp_s;

  int checks   = 0;
  int failures = 0;

  cmd_s cmd_q[$];   // accepted, not yet issued
  exp_s exp_q[$];   // issued, response expected

  // ALU responder configuration: >0 fixed done delay, 0 random 1..8, -1 never done
  int   cfg_dly = 4;
  bit   stray   = 1'b0;
  bit   rr_rand = 1'b0;
  bit   pend    = 1'b0;
  int   done_at = 0;
  logic [WIDTH-1:0] pend_res;
  cmd_s issued;

  int cyc = 0;
  int en_count = 0, rsp_count = 0, acc_count = 0;
  int last_en_cyc = 0, last_acc_cyc = 0, rsp_first_cyc = 0;
  bit prev_en = 1'b0, prev_rv = 1'b0;
  logic [1:0]       snap_op;
  logic [WIDTH-1:0] snap_res;
  logic             snap_err;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a - b;
      2'd1:    return a + b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: account for what the DUT sees at the coming edge, then
  // drive the responder inputs for the following cycle.
  task automatic tick();
    cmd_s c;
    exp_s e;
    int   dly;
    if (bus.cmd_valid && bus.cmd_ready) begin
      c.op = bus.cmd_opcode; c.a = bus.cmd_a; c.b = bus.cmd_b;
      cmd_q.push_back(c);
      acc_count++;
      last_acc_cyc = cyc;
    end
    if (bus.alu_en) begin
      en_count++;
      last_en_cyc = cyc;
      check("en_single_cycle", 32'(prev_en), 0);
      check("en_while_rsp_valid", 32'(bus.rsp_valid), 0);
      check("en_with_cmd_pending", 32'(cmd_q.size() != 0), 1);
      pend = 1'b0;
      if (cmd_q.size() != 0) begin
        c = cmd_q.pop_front();
        check("issue_opcode", 32'(bus.alu_opcode), 32'(c.op));
        check("issue_a", 32'(bus.alu_a), 32'(c.a));
        check("issue_b", 32'(bus.alu_b), 32'(c.b));
        dly   = (cfg_dly == 0) ? int'($urandom_range(1, 8)) : cfg_dly;
        e.op  = c.op;
        e.err = (cfg_dly < 0) || (dly > TIMEOUT);
        e.res = e.err ? '0 : alu_fn(c.op, c.a, c.b);
        e.lat = e.err ? 32'(TIMEOUT + 1) : 32'(dly + 1);
        exp_q.push_back(e);
        issued.op = bus.alu_opcode; issued.a = bus.alu_a; issued.b = bus.alu_b;
        if (cfg_dly >= 0) begin
          pend     = 1'b1;
          done_at  = cyc + dly;
          pend_res = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
        end
      end
    end
    if (bus.alu_done && pend && cyc == done_at) begin
      check("hold_opcode", 32'(bus.alu_opcode), 32'(issued.op));
      check("hold_a", 32'(bus.alu_a), 32'(issued.a));
      check("hold_b", 32'(bus.alu_b), 32'(issued.b));
      pend = 1'b0;
    end
    if (bus.rsp_valid) begin
      if (!prev_rv) begin
        rsp_first_cyc = cyc;
        snap_op = bus.rsp_opcode; snap_res = bus.rsp_res; snap_err = bus.rsp_err;
      end else begin
        check("rsp_stable_opcode", 32'(bus.rsp_opcode), 32'(snap_op));
        check("rsp_stable_res", 32'(bus.rsp_res), 32'(snap_res));
        check("rsp_stable_err", 32'(bus.rsp_err), 32'(snap_err));
      end
      if (bus.rsp_ready) begin
        rsp_count++;
        check("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_opcode", 32'(bus.rsp_opcode), 32'(e.op));
          check("rsp_res", 32'(bus.rsp_res), 32'(e.res));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_latency", 32'(rsp_first_cyc - last_en_cyc), e.lat);
        end
      end
    end
    prev_en = bus.alu_en;
    prev_rv = bus.rsp_valid && !bus.rsp_ready;
    @(posedge clk);
    #1;
    cyc++;
    bus.alu_done = stray || (pend && cyc == done_at);
    bus.alu_res  = (pend && cyc == done_at) ? pend_res : WIDTH'($urandom());
    if (rr_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.alu_done  = 1'b0;
    pend  = 1'b0;
    stray = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    cmd_q.delete();
    exp_q.delete();
    prev_en = 1'b0;
    prev_rv = 1'b0;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n0;
    int k;
    n0 = acc_count;
    k  = 0;
    bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b;
    while (acc_count == n0 && k < 500) begin
      tick();
      k++;
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", 32'(acc_count != n0), 1);
  endtask

  task automatic push_rand();
    push_cmd(2'($urandom_range(0, 3)), WIDTH'($urandom()), WIDTH'($urandom()));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && (bus.busy || bus.rsp_valid || cmd_q.size() != 0 || exp_q.size() != 0)) begin
      tick();
      k++;
    end
    check(tag, 32'(k < budget), 1);
  endtask

  task automatic wait_rsp_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && !bus.rsp_valid) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.rsp_valid), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en0, rsp0, acc0;
    logic [1:0]       hop;
    logic [WIDTH-1:0] ha, hb;

    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.alu_done  = 1'b0; bus.alu_res = '0; bus.rsp_ready = 1'b1;
    do_reset(3);

    // Reset state
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_alu_en", 32'(bus.alu_en), 0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 0);
    check("rst_alu_a", 32'(bus.alu_a), 0);
    check("rst_alu_b", 32'(bus.alu_b), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_opcode", 32'(bus.rsp_opcode), 0);
    check("rst_rsp_res", 32'(bus.rsp_res), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_busy", 32'(bus.busy), 0);

    // Single op: opcode 1, 5+3, done 4 cycles after en
    cfg_dly = 4; en0 = en_count; rsp0 = rsp_count;
    push_cmd(2'd1, 8'd5, 8'd3);
    wait_idle("t1_drain", 100);
    check("t1_en_pulses", 32'(en_count - en0), 1);
    check("t1_en_latency", 32'(last_en_cyc - last_acc_cyc), 2);
    check("t1_rsp_count", 32'(rsp_count - rsp0), 1);

    // Burst into a stalled issuer: FIFO fills after 4 accepts
    cfg_dly = 3; en0 = en_count; rsp0 = rsp_count;
    bus.rsp_ready = 1'b0;
    push_rand();
    wait_rsp_valid("t2_first_rsp", 50);
    repeat (4) push_rand();
    check("t2_full_cmd_ready", 32'(bus.cmd_ready), 0);
    check("t2_busy", 32'(bus.busy), 1);
    acc0 = acc_count;
    hop = 2'($urandom_range(0, 3)); ha = WIDTH'($urandom()); hb = WIDTH'($urandom());
    bus.cmd_valid = 1'b1; bus.cmd_opcode = hop; bus.cmd_a = ha; bus.cmd_b = hb;
    repeat (3) tick();
    check("t2_no_push_when_full", 32'(acc_count - acc0), 0);
    bus.rsp_ready = 1'b1;
    push_cmd(hop, ha, hb);
    wait_idle("t2_drain", 500);
    check("t2_en_pulses", 32'(en_count - en0), 6);
    check("t2_rsp_count", 32'(rsp_count - rsp0), 6);

    // Backpressure: response held 10 cycles, next command waits
    cfg_dly = 2; en0 = en_count;
    bus.rsp_ready = 1'b0;
    push_rand();
    push_rand();
    wait_rsp_valid("t3_rsp", 50);
    repeat (10) tick();
    check("t3_rsp_still_valid", 32'(bus.rsp_valid), 1);
    check("t3_no_issue_during_bp", 32'(en_count - en0), 1);
    bus.rsp_ready = 1'b1;
    wait_idle("t3_drain", 100);
    check("t3_en_pulses", 32'(en_count - en0), 2);

    // Timeout, then a queued command issues normally
    cfg_dly = -1; en0 = en_count;
    push_rand();
    push_rand();
    wait_rsp_valid("t4_timeout_rsp", 200);
    check("t4_err", 32'(bus.rsp_err), 1);
    check("t4_res_zero", 32'(bus.rsp_res), 0);
    check("t4_timeout_cycles", 32'(cyc - last_en_cyc), 32'(TIMEOUT + 1));
    cfg_dly = 5;
    wait_idle("t4_drain", 200);
    check("t4_en_pulses", 32'(en_count - en0), 2);

    // Stray done while idle produces nothing
    en0 = en_count; rsp0 = rsp_count;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (8) tick();
    check("t5_stray_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t5_stray_busy", 32'(bus.busy), 0);
    check("t5_stray_rsp_count", 32'(rsp_count - rsp0), 0);
    check("t5_stray_en", 32'(en_count - en0), 0);

    // Done exactly on the timeout cycle wins; one cycle later is too late
    cfg_dly = TIMEOUT;
    push_cmd(2'd1, 8'd100, 8'd27);
    wait_idle("t5_edge_drain", 300);
    cfg_dly = TIMEOUT + 1;
    push_cmd(2'd3, 8'h5a, 8'h0f);
    wait_idle("t5_late_drain", 300);

    // Reset while waiting with two commands queued
    cfg_dly = -1; en0 = en_count;
    push_rand();
    push_rand();
    push_rand();
    repeat (5) tick();
    check("t6_busy_before_rst", 32'(bus.busy), 1);
    do_reset(1);
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_cmd_ready", 32'(bus.cmd_ready), 1);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t6_alu_en", 32'(bus.alu_en), 0);
    en0 = en_count; rsp0 = rsp_count;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (10) tick();
    check("t6_late_done_en", 32'(en_count - en0), 0);
    check("t6_late_done_rsp", 32'(rsp_count - rsp0), 0);
    check("t6_late_rsp_valid", 32'(bus.rsp_valid), 0);

    // Random traffic with random backpressure and done delays
    cfg_dly = 0; rr_rand = 1'b1; rsp0 = rsp_count;
    for (int i = 0; i < 40; i++) begin
      push_rand();
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand_drain", 3000);
    rr_rand = 1'b0;
    bus.rsp_ready = 1'b1;
    check("rand_rsp_count", 32'(rsp_count - rsp0), 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
